// File: rtl/hazard_seq_unit_if.sv
// Pipeline-side hazard request/response bundle for hazard_seq_unit.
// The master is the pipeline control logic and the slave is the hazard sequencer.
interface hazard_seq_unit_if;
   logic       i_push_pc;
   logic       i_pop_pc;
   logic       i_branch_decision;
   logic       i_decode_imm;
   logic       i_exm_imm;
   logic       i_interrupt_call;
   logic       i_load_use;
   logic       o_flush_f_d;
   logic       o_stall_f_d;
   logic       o_flush_d_em;
   logic       o_stall_d_em;
   logic       o_stall_interrupt;
   logic       o_branch_decision;
   logic [1:0] o_state;
   logic       o_busy;

   modport master (
      output i_push_pc, i_pop_pc, i_branch_decision, i_decode_imm,
             i_exm_imm, i_interrupt_call, i_load_use,
      input  o_flush_f_d, o_stall_f_d, o_flush_d_em, o_stall_d_em,
             o_stall_interrupt, o_branch_decision, o_state, o_busy
   );

   modport slave (
      input  i_push_pc, i_pop_pc, i_branch_decision, i_decode_imm,
             i_exm_imm, i_interrupt_call, i_load_use,
      output o_flush_f_d, o_stall_f_d, o_flush_d_em, o_stall_d_em,
             o_stall_interrupt, o_branch_decision, o_state, o_busy
   );
endinterface

// File: rtl/hazard_seq_unit.sv
// Hazard sequencer: stalls D/EM for call/ret PC push/pop sequences and merges
// branch, load-use, immediate-word and interrupt-deferral hazards.
module hazard_seq_unit #(
   parameter int PUSH_CYCLES = 1,
   parameter int POP_CYCLES  = 1,
   parameter int CNT_W       = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   hazard_seq_unit_if.slave    bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RELEASE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] PUSH_N  = CNT_W'(PUSH_CYCLES);
   localparam logic [CNT_W-1:0] POP_N   = CNT_W'(POP_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   state_t           state_r;
   state_t           state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             op_r;
   logic             op_nxt_s;
   logic             busy_r;

   logic             trigger_s;
   logic             trig_op_s;
   logic [CNT_W-1:0] trig_n_s;
   logic             release_pop_s;

   logic             flush_f_d_s;
   logic             stall_f_d_s;
   logic             flush_d_em_s;
   logic             stall_d_em_s;
   logic             stall_interrupt_s;
   logic             branch_decision_s;

   // Trigger decode: a call/ret is only accepted in IDLE, and pop has priority.
   always_comb begin
      trigger_s     = (state_r == ST_IDLE) && (bus.i_push_pc || bus.i_pop_pc);
      trig_op_s     = bus.i_pop_pc;
      trig_n_s      = bus.i_pop_pc ? POP_N : PUSH_N;
      release_pop_s = (state_r == ST_RELEASE) && op_r;
   end

   // Next-state, stall counter and op-flag logic.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      op_nxt_s    = op_r;
      case (state_r)
         ST_IDLE: begin
            if (trigger_s) begin
               op_nxt_s = trig_op_s;
               if (trig_n_s == CNT_ONE) begin
                  state_nxt_s = ST_RELEASE;
               end else begin
                  state_nxt_s = ST_WAIT;
                  cnt_nxt_s   = trig_n_s - CNT_ONE;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            cnt_nxt_s = cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
               state_nxt_s = ST_RELEASE;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         ST_RELEASE: begin
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
         end
      endcase
   end

   // State register; busy mirrors the registered state so it never glitches.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= ST_IDLE;
         cnt_r   <= CNT_ZERO;
         op_r    <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         op_r    <= op_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
      end
   end

   // Hazard outputs; a D/EM stall wins over a branch-induced D/EM flush.
   always_comb begin
      flush_f_d_s       = 1'b0;
      stall_f_d_s       = 1'b0;
      flush_d_em_s      = 1'b0;
      stall_d_em_s      = 1'b0;
      stall_interrupt_s = 1'b0;
      branch_decision_s = 1'b0;
      if (!i_rst) begin
         stall_d_em_s      = trigger_s || (state_r == ST_WAIT);
         stall_f_d_s       = (state_r == ST_IDLE) && bus.i_load_use &&
                             !trigger_s && !bus.i_branch_decision;
         flush_f_d_s       = bus.i_branch_decision;
         branch_decision_s = bus.i_branch_decision || release_pop_s;
         flush_d_em_s      = (bus.i_branch_decision && !stall_d_em_s) ||
                             release_pop_s || stall_f_d_s || bus.i_exm_imm;
         stall_interrupt_s = bus.i_interrupt_call &&
                             (bus.i_decode_imm || busy_r || trigger_s);
      end else begin
         flush_f_d_s       = 1'b0;
         stall_f_d_s       = 1'b0;
         flush_d_em_s      = 1'b0;
         stall_d_em_s      = 1'b0;
         stall_interrupt_s = 1'b0;
         branch_decision_s = 1'b0;
      end
   end

   assign bus.o_flush_f_d       = flush_f_d_s;
   assign bus.o_stall_f_d       = stall_f_d_s;
   assign bus.o_flush_d_em      = flush_d_em_s;
   assign bus.o_stall_d_em      = stall_d_em_s;
   assign bus.o_stall_interrupt = stall_interrupt_s;
   assign bus.o_branch_decision = branch_decision_s;
   assign bus.o_state           = state_r;
   assign bus.o_busy            = busy_r;

endmodule

// File: tb/tb_hazard_seq_unit.sv
// Scoreboard bench for hazard_seq_unit: one default-parameter instance and one
// with PUSH_CYCLES=3 / POP_CYCLES=2, driven with hand-computed vectors.
module tb_hazard_seq_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Input vector: {rst, pop, push, br, dimm, eimm, intr, lu}
   logic [7:0] in0;
   logic [7:0] in1;
   // Output vector: {state[1:0], busy, ffd, sfd, fdem, sdem, sint, bdec}
   logic [8:0] act0;
   logic [8:0] act1;

   hazard_seq_unit_if bus0 ();
   hazard_seq_unit_if bus1 ();

   assign bus0.i_pop_pc          = in0[6];
   assign bus0.i_push_pc         = in0[5];
   assign bus0.i_branch_decision = in0[4];
   assign bus0.i_decode_imm      = in0[3];
   assign bus0.i_exm_imm         = in0[2];
   assign bus0.i_interrupt_call  = in0[1];
   assign bus0.i_load_use        = in0[0];

   assign bus1.i_pop_pc          = in1[6];
   assign bus1.i_push_pc         = in1[5];
   assign bus1.i_branch_decision = in1[4];
   assign bus1.i_decode_imm      = in1[3];
   assign bus1.i_exm_imm         = in1[2];
   assign bus1.i_interrupt_call  = in1[1];
   assign bus1.i_load_use        = in1[0];

   assign act0 = {bus0.o_state, bus0.o_busy, bus0.o_flush_f_d, bus0.o_stall_f_d,
                  bus0.o_flush_d_em, bus0.o_stall_d_em, bus0.o_stall_interrupt,
                  bus0.o_branch_decision};
   assign act1 = {bus1.o_state, bus1.o_busy, bus1.o_flush_f_d, bus1.o_stall_f_d,
                  bus1.o_flush_d_em, bus1.o_stall_d_em, bus1.o_stall_interrupt,
                  bus1.o_branch_decision};

   hazard_seq_unit dut_def (
      .i_clk (clk),
      .i_rst (in0[7]),
      .bus   (bus0)
   );

   hazard_seq_unit #(
      .PUSH_CYCLES (3),
      .POP_CYCLES  (2),
      .CNT_W       (4)
   ) dut_par (
      .i_clk (clk),
      .i_rst (in1[7]),
      .bus   (bus1)
   );

   typedef struct {
      logic       sel;
      logic [8:0] exp_v;
      string      name;
   } exp_t;

   exp_t q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   task automatic apply(input logic sel, input string name,
                        input logic [7:0] in_v, input logic [8:0] exp_v);
      exp_t e;
      if (sel == 1'b0) begin
         in0 = in_v;
         in1 = 8'b0_000_0000;
      end else begin
         in0 = 8'b0_000_0000;
         in1 = in_v;
      end
      e.sel   = sel;
      e.exp_v = exp_v;
      e.name  = name;
      q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare on the falling edge, away from the active edge.
   initial begin
      exp_t       e;
      logic [8:0] got;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e   = q.pop_front();
            got = e.sel ? act1 : act0;
            n_vec++;
            if (got !== e.exp_v) begin
               n_fail++;
               $display("FAIL %s: got %b expected %b (st_busy_ffd_sfd_fdem_sdem_sint_bdec)",
                        e.name, got, e.exp_v);
            end
         end
      end
   end

   initial begin
      in0 = 8'b1_000_0000;
      in1 = 8'b1_000_0000;
      repeat (2) @(posedge clk);
      #1;

      // Default instance: PUSH_CYCLES=1, POP_CYCLES=1
      apply(1'b0, "reset_hold",      8'b1_000_0000, 9'b00_0_0000_00);
      apply(1'b0, "idle",            8'b0_000_0000, 9'b00_0_0000_00);
      apply(1'b0, "pop_c0",          8'b0_100_0000, 9'b00_0_0001_00);
      apply(1'b0, "pop_c1_release",  8'b0_000_0000, 9'b10_1_0010_01);
      apply(1'b0, "pop_c2_idle",     8'b0_000_0000, 9'b00_0_0000_00);
      apply(1'b0, "push_c0",         8'b0_010_0000, 9'b00_0_0001_00);
      apply(1'b0, "push_c1_release", 8'b0_000_0000, 9'b10_1_0000_00);
      apply(1'b0, "push_c2_idle",    8'b0_000_0000, 9'b00_0_0000_00);
      apply(1'b0, "br_push_same",    8'b0_011_0000, 9'b00_0_1001_01);
      apply(1'b0, "br_push_release", 8'b0_000_0000, 9'b10_1_0000_00);
      apply(1'b0, "load_use",        8'b0_000_0001, 9'b00_0_0110_00);
      apply(1'b0, "load_use_br",     8'b0_001_0001, 9'b00_0_1010_01);
      apply(1'b0, "exm_imm",         8'b0_000_0100, 9'b00_0_0010_00);
      apply(1'b0, "intr_dimm",       8'b0_000_1010, 9'b00_0_0000_10);
      apply(1'b0, "intr_idle",       8'b0_000_0010, 9'b00_0_0000_00);
      apply(1'b0, "pop_push_both",   8'b0_110_0000, 9'b00_0_0001_00);
      apply(1'b0, "pop_wins_rel",    8'b0_000_0000, 9'b10_1_0010_01);
      apply(1'b0, "both_idle",       8'b0_000_0000, 9'b00_0_0000_00);

      // Parameterised instance: PUSH_CYCLES=3, POP_CYCLES=2
      apply(1'b1, "p_idle",          8'b0_000_0000, 9'b00_0_0000_00);
      apply(1'b1, "push3_c0",        8'b0_010_0000, 9'b00_0_0001_00);
      apply(1'b1, "push3_c1",        8'b0_010_0000, 9'b01_1_0001_00);
      apply(1'b1, "push3_c2",        8'b0_010_0000, 9'b01_1_0001_00);
      apply(1'b1, "push3_c3_rel",    8'b0_010_0000, 9'b10_1_0000_00);
      apply(1'b1, "push3_c4_idle",   8'b0_000_0000, 9'b00_0_0000_00);
      apply(1'b1, "wbr_c0",          8'b0_010_0000, 9'b00_0_0001_00);
      apply(1'b1, "wbr_c1_br_wait",  8'b0_001_0000, 9'b01_1_1001_01);
      apply(1'b1, "wbr_c2_lu_wait",  8'b0_000_0001, 9'b01_1_0001_00);
      apply(1'b1, "wbr_c3_br_rel",   8'b0_001_0000, 9'b10_1_1010_01);
      apply(1'b1, "wbr_c4_idle",     8'b0_000_0000, 9'b00_0_0000_00);
      apply(1'b1, "pop2_int_c0",     8'b0_100_0010, 9'b00_0_0001_10);
      apply(1'b1, "pop2_int_c1",     8'b0_000_0010, 9'b01_1_0001_10);
      apply(1'b1, "pop2_int_c2",     8'b0_000_0010, 9'b10_1_0010_11);
      apply(1'b1, "pop2_int_c3",     8'b0_000_0010, 9'b00_0_0000_00);
      apply(1'b1, "rst_seq_c0",      8'b0_010_0000, 9'b00_0_0001_00);
      apply(1'b1, "rst_in_wait",     8'b1_001_0110, 9'b01_1_0000_00);
      apply(1'b1, "rst_after_c0",    8'b0_000_0000, 9'b00_0_0000_00);
      apply(1'b1, "rst_after_c1",    8'b0_000_0000, 9'b00_0_0000_00);

      in0 = 8'b0_000_0000;
      in1 = 8'b0_000_0000;
      for (int i = 0; i < 10 && q.size() > 0; i++) begin
         @(negedge clk);
      end
      #1;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
